// File: rtl/clock_divider_if.sv
// rtl/clock_divider_if.sv - strobe output bundle of the tick generator
//
// Purpose:
//   Carries the one-cycle clock-enable strobe from the divider to its consumer.
//
// Signals:
//   clkOUT  strobe, high for one clkIN cycle once per division period
//
// Modports:
//   master  driven by the divider (clkOUT is an output)
//   slave   seen by the consumer (clkOUT is an input)

interface clock_divider_if;
    logic clkOUT;

    modport master (output clkOUT);
    modport slave  (input  clkOUT);
endinterface

// File: rtl/clock_divider.sv
// rtl/clock_divider.sv - integer clock divider producing a one-cycle tick strobe
//
// Purpose:
//   Counts clkIN cycles and emits a single-cycle strobe once every VALUE
//   cycles. The strobe is meant as a clock-enable for logic running on clkIN,
//   not as a derived clock. Asserting nResetIN re-phases the divider so that
//   the first strobe after release lands exactly VALUE edges later.
//
// Parameters:
//   VALUE     division ratio in clkIN cycles, 1 .. 2^32-1 (0 is rejected)
//
// Ports:
//   clkIN     system clock, all state changes on its rising edge
//   nResetIN  asynchronous active-low reset, clears counter and strobe at once
//   tickIf    master side of clock_divider_if, carries the clkOUT strobe

module clock_divider #(
    parameter int unsigned VALUE = 2
) (
    input  logic              clkIN,
    input  logic              nResetIN,
    clock_divider_if.master   tickIf
);

    // A ratio of zero has no meaning; stop elaboration rather than build
    // something that silently never ticks.
    generate
        if (VALUE == 0) begin : gInvalidValue
            $error("clock_divider: VALUE must be at least 1");
        end
    endgenerate

    // Counter width: enough bits to hold VALUE-1, never less than one bit so
    // the VALUE = 1 case still has a well-formed (constant zero) counter.
    localparam int CNT_W = (VALUE > 1) ? $clog2(VALUE) : 1;

    // Terminal count. The counter wraps from here back to zero on the same
    // edge that raises the strobe, so the period is exactly VALUE edges.
    localparam logic [CNT_W-1:0] LAST = CNT_W'(VALUE - 1);

    logic [CNT_W-1:0] cnt;
    logic             strobe;

    // Counter and strobe share one register stage, so clkOUT is a pure flop
    // output. Reset is asynchronous: the strobe drops the moment nResetIN
    // falls, even mid-cycle while it is high.
    always_ff @(posedge clkIN or negedge nResetIN) begin
        if (!nResetIN) begin
            cnt    <= '0;
            strobe <= 1'b0;
        end else if (cnt == LAST) begin
            cnt    <= '0;
            strobe <= 1'b1;
        end else begin
            cnt    <= cnt + 1'b1;
            strobe <= 1'b0;
        end
    end

    assign tickIf.clkOUT = strobe;

endmodule

// File: tb/tb_clock_divider.sv
// tb/tb_clock_divider.sv - self-checking bench for clock_divider

module tb_clock_divider;

    localparam int NDUT = 5;
    // Ratios of the five instances: basic, receiver period, re-phase, async, degenerate.
    localparam int V0 = 4;
    localparam int V1 = 14060;
    localparam int V2 = 10;
    localparam int V3 = 3;
    localparam int V4 = 1;

    int vals [NDUT] = '{V0, V1, V2, V3, V4};

    logic            clk = 1'b0;
    logic [NDUT-1:0] nRst = '0;
    logic [NDUT-1:0] outs;

    int checks = 0;
    int errors = 0;

    // Edges seen since the most recent reset release, per instance.
    int edgesSinceRelease [NDUT];

    always #5 clk = ~clk;

    clock_divider_if if0 ();
    clock_divider_if if1 ();
    clock_divider_if if2 ();
    clock_divider_if if3 ();
    clock_divider_if if4 ();

    clock_divider #(.VALUE(V0)) u0 (.clkIN(clk), .nResetIN(nRst[0]), .tickIf(if0));
    clock_divider #(.VALUE(V1)) u1 (.clkIN(clk), .nResetIN(nRst[1]), .tickIf(if1));
    clock_divider #(.VALUE(V2)) u2 (.clkIN(clk), .nResetIN(nRst[2]), .tickIf(if2));
    clock_divider #(.VALUE(V3)) u3 (.clkIN(clk), .nResetIN(nRst[3]), .tickIf(if3));
    clock_divider #(.VALUE(V4)) u4 (.clkIN(clk), .nResetIN(nRst[4]), .tickIf(if4));

    assign outs = {if4.clkOUT, if3.clkOUT, if2.clkOUT, if1.clkOUT, if0.clkOUT};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Model: the strobe is high exactly when a positive multiple of VALUE
    // edges has elapsed since release, and low whenever reset is asserted.
    always @(posedge clk) begin
        for (int i = 0; i < NDUT; i++) begin
            if (!nRst[i]) edgesSinceRelease[i] <= 0;
            else          edgesSinceRelease[i] <= edgesSinceRelease[i] + 1;
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < NDUT; i++) begin
            logic expv;
            expv = nRst[i] && (edgesSinceRelease[i] > 0) &&
                   (edgesSinceRelease[i] % vals[i] == 0);
            check($sformatf("model_dut%0d_k%0d", i, edgesSinceRelease[i]),
                  {31'd0, outs[i]}, {31'd0, expv});
        end
    end

    task automatic releaseAfterEdge(input int i);
        @(posedge clk);
        #1;
        nRst[i] = 1'b1;
    endtask

    // Counts edges until the strobe of instance i is seen high; returns
    // budget+1 if it never shows up.
    task automatic edgesToStrobe(input int i, input int budget, output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!outs[i] && n <= budget);
    endtask

    int pulses[$];
    int expPulses [5] = '{4, 8, 12, 16, 20};
    int n;

    initial begin
        // Reset state: every instance held low.
        repeat (3) @(posedge clk);
        #1;
        check("reset_outs", {27'd0, outs}, 32'd0);
        check("reset_cnt_dut3", {30'd0, u3.cnt}, 32'd0);

        // Basic strobe, VALUE = 4: pulses only after edges 4, 8, 12, 16, 20.
        releaseAfterEdge(0);
        for (int e = 1; e <= 20; e++) begin
            @(posedge clk);
            #1;
            if (outs[0]) pulses.push_back(e);
        end
        check("v4_pulse_count", pulses.size(), 5);
        for (int j = 0; j < 5 && j < pulses.size(); j++)
            check($sformatf("v4_pulse_edge%0d", j), pulses[j], expPulses[j]);

        // Held reset: 100 cycles low keeps the strobe low, then resumes.
        nRst[0] = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(posedge clk);
            #1;
            if (c == 0 || c == 50 || c == 99)
                check($sformatf("held_low_c%0d", c), {31'd0, outs[0]}, 32'd0);
        end
        releaseAfterEdge(0);
        edgesToStrobe(0, 10, n);
        check("held_first_strobe", n, 4);

        // Re-phase, VALUE = 10: one-cycle reset pulse after 7 edges.
        releaseAfterEdge(2);
        repeat (7) @(posedge clk);
        #1;
        nRst[2] = 1'b0;
        releaseAfterEdge(2);
        edgesToStrobe(2, 30, n);
        check("rephase_first_strobe", n, 10);
        edgesToStrobe(2, 30, n);
        check("rephase_period", n, 10);

        // Async reset while strobe is high, VALUE = 3.
        releaseAfterEdge(3);
        repeat (3) @(posedge clk);
        #1;
        check("v3_strobe_high", {31'd0, outs[3]}, 32'd1);
        #1;
        nRst[3] = 1'b0;
        #1;
        check("v3_async_clear_out", {31'd0, outs[3]}, 32'd0);
        check("v3_async_clear_cnt", {30'd0, u3.cnt}, 32'd0);
        releaseAfterEdge(3);
        edgesToStrobe(3, 10, n);
        check("v3_after_async", n, 3);

        // Degenerate VALUE = 1: high on every edge after release.
        check("v1_in_reset", {31'd0, outs[4]}, 32'd0);
        releaseAfterEdge(4);
        for (int e = 1; e <= 10; e++) begin
            @(posedge clk);
            #1;
            check($sformatf("v1_edge%0d", e), {31'd0, outs[4]}, 32'd1);
        end
        nRst[4] = 1'b0;
        #1;
        check("v1_reset_drop", {31'd0, outs[4]}, 32'd0);

        // Receiver period, VALUE = 14060.
        releaseAfterEdge(1);
        edgesToStrobe(1, 20000, n);
        check("v14060_first_strobe", n, 14060);
        edgesToStrobe(1, 20000, n);
        check("v14060_spacing", n, 14060);

        @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1);
    end

endmodule
